// File: rtl/pmu_arb_pkg.sv
// Shared types and constants for the PMU AHB arbiter: FSM states, AHB encodings
// and the id-width helper.
package pmu_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_ERR
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Width of a requester id; never below 1 so single-bit vectors stay legal.
    function automatic int pmu_log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/pmu_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns both a one-hot grant and the binary id.
module pmu_rr_arbiter
    import pmu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = pmu_log2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pmu_ahb_arbiter.sv
// Round-robin sharing of the PMU AHB-lite slave port between N_REQ clients;
// one single-beat NONSEQ transfer at a time with a wait-state timeout.
module pmu_ahb_arbiter
    import pmu_arb_pkg::*;
#(
    parameter int                     N_REQ       = 2,
    parameter int                     HADDR_WIDTH = 32,
    parameter int                     HDATA_WIDTH = 32,
    parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h80100000,
    parameter logic [HADDR_WIDTH-1:0] ADDR_MASK   = 32'h00000fff,
    parameter int                     TIMEOUT     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ-1:0]             we_i,
    input  logic [N_REQ*HADDR_WIDTH-1:0] addr_i,
    input  logic [N_REQ*HDATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic [N_REQ-1:0]             rsp_valid_o,
    output logic                         rsp_err_o,
    output logic [HDATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                         busy_o,
    output logic                         hsel_o,
    output logic [HADDR_WIDTH-1:0]       haddr_o,
    output logic                         hwrite_o,
    output logic [1:0]                   htrans_o,
    output logic [HDATA_WIDTH-1:0]       hwdata_o,
    input  logic                         hreadyo_i,
    input  logic [1:0]                   hresp_i,
    input  logic [HDATA_WIDTH-1:0]       hrdata_i
);

    localparam int ID_W  = pmu_log2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t             state_reg, state_next;
    logic [ID_W-1:0]        ptr_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [ID_W-1:0]        id_reg;
    logic                   we_reg;
    logic [HADDR_WIDTH-1:0] addr_reg;
    logic [HDATA_WIDTH-1:0] wdata_reg;
    logic [HDATA_WIDTH-1:0] rdata_reg;
    logic                   err_reg;

    logic [HADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [HDATA_WIDTH-1:0] wdata_arr [N_REQ];
    logic [N_REQ-1:0]       arb_gnt;
    logic [ID_W-1:0]        arb_id;
    logic [HADDR_WIDTH-1:0] addr_sel;
    logic                   addr_bad;
    logic                   grant_any;
    logic                   timeout_hit;
    logic                   resp_phase;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*HADDR_WIDTH +: HADDR_WIDTH];
            assign wdata_arr[gi] = wdata_i[gi*HDATA_WIDTH +: HDATA_WIDTH];
        end
    endgenerate

    pmu_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req (req_i),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    // Grants exist only while idle; a reset cycle never hands out a grant.
    assign gnt_o     = (state_reg == ST_IDLE && !rst_i) ? arb_gnt : '0;
    assign grant_any = |gnt_o;
    assign addr_sel  = addr_arr[arb_id];
    assign addr_bad  = ((addr_sel & ~ADDR_MASK) != BASE_ADDR) || (addr_sel[1:0] != 2'b00);
    assign timeout_hit = !hreadyo_i && (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign resp_phase  = (state_reg == ST_RESP) || (state_reg == ST_ERR);

    always_comb begin
        state_next = state_reg;
        hsel_o     = 1'b0;
        htrans_o   = HTRANS_IDLE;
        hwrite_o   = 1'b0;
        busy_o     = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    state_next = addr_bad ? ST_ERR : ST_ADDR;
                end
            end
            ST_ADDR: begin
                hsel_o   = 1'b1;
                htrans_o = HTRANS_NONSEQ;
                hwrite_o = we_reg;
                if (hreadyo_i) begin
                    state_next = ST_DATA;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_DATA: begin
                if (hreadyo_i) begin
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                end
            end
            ST_RESP, ST_ERR: state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            id_reg    <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && grant_any) begin
                id_reg    <= arb_id;
                we_reg    <= we_i[arb_id];
                addr_reg  <= addr_sel;
                wdata_reg <= wdata_arr[arb_id];
            end
            // Wait states accumulate across ADDR and DATA of one transfer.
            if (state_next == ST_ADDR && state_reg != ST_ADDR) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_ADDR || state_reg == ST_DATA) && !hreadyo_i) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (state_reg == ST_DATA && hreadyo_i) begin
                rdata_reg <= we_reg ? '0 : hrdata_i;
                err_reg   <= (hresp_i != HRESP_OKAY);
            end else if (state_next == ST_ERR) begin
                rdata_reg <= '0;
                err_reg   <= 1'b1;
            end
            if (resp_phase) begin
                ptr_reg <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + ID_W'(1);
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign rsp_valid_o[gi] = resp_phase && (id_reg == ID_W'(gi));
        end
    endgenerate

    assign rsp_err_o   = resp_phase && err_reg;
    assign rsp_rdata_o = rdata_reg;
    assign haddr_o     = addr_reg;
    assign hwdata_o    = wdata_reg;

endmodule

// File: tb/tb_pmu_ahb_arbiter.sv
// Self-checking bench for pmu_ahb_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level reference model.
module tb_pmu_ahb_arbiter;

    localparam int N = 2;
    localparam int T = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N-1:0]    we_i;
    logic [N*32-1:0] addr_i;
    logic [N*32-1:0] wdata_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rsp_valid_o;
    logic            rsp_err_o;
    logic [31:0]     rsp_rdata_o;
    logic            busy_o;
    logic            hsel_o;
    logic [31:0]     haddr_o;
    logic            hwrite_o;
    logic [1:0]      htrans_o;
    logic [31:0]     hwdata_o;
    logic            hreadyo_i;
    logic [1:0]      hresp_i;
    logic [31:0]     hrdata_i;

    logic [31:0] a_addr  [N];
    logic [31:0] a_wdata [N];
    logic        a_we    [N];

    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    always_comb begin
        addr_i  = '0;
        wdata_i = '0;
        we_i    = '0;
        for (int i = 0; i < N; i++) begin
            addr_i[i*32 +: 32]  = a_addr[i];
            wdata_i[i*32 +: 32] = a_wdata[i];
            we_i[i]             = a_we[i];
        end
    end

    pmu_ahb_arbiter #(
        .N_REQ       (N),
        .HADDR_WIDTH (32),
        .HDATA_WIDTH (32),
        .BASE_ADDR   (32'h80100000),
        .ADDR_MASK   (32'h00000fff),
        .TIMEOUT     (T)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_rdata_o (rsp_rdata_o),
        .busy_o      (busy_o),
        .hsel_o      (hsel_o),
        .haddr_o     (haddr_o),
        .hwrite_o    (hwrite_o),
        .htrans_o    (htrans_o),
        .hwdata_o    (hwdata_o),
        .hreadyo_i   (hreadyo_i),
        .hresp_i     (hresp_i),
        .hrdata_i    (hrdata_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    function automatic bit addr_is_bad(input logic [31:0] a);
        return ((a & 32'hfffff000) != 32'h80100000) || (a[1:0] != 2'b00);
    endfunction

    // One transaction: sa wait cycles in the address phase, sd in the data phase.
    task automatic run_txn(input string tag, input logic [N-1:0] mask, input int sa,
                           input int sd, input logic [31:0] sdata, input bit serr);
        int          w;
        int          r;
        bit          bad;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [N-1:0] exp_onehot;
        w   = rr_pick(mask, m_ptr);
        bad = addr_is_bad(a_addr[w]);
        exp_onehot    = '0;
        exp_onehot[w] = 1'b1;
        if (bad) begin
            r = 1; exp_err = 1'b1; exp_rdata = '0;
        end else if (sa >= T) begin
            r = T + 1; exp_err = 1'b1; exp_rdata = '0;
        end else if (sa + sd >= T) begin
            r = T + 2; exp_err = 1'b1; exp_rdata = '0;
        end else begin
            r = sa + sd + 3; exp_err = serr; exp_rdata = a_we[w] ? 32'h0 : sdata;
        end

        tick();
        req_i     = mask;
        hrdata_i  = sdata;
        hresp_i   = serr ? 2'b01 : 2'b00;
        hreadyo_i = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_o !== exp_onehot) begin
            errors++;
            $display("FAIL %s gnt got %b exp %b", tag, gnt_o, exp_onehot);
        end
        checks++;
        if (busy_o !== 1'b0 || rsp_rdata_o !== last_rdata) begin
            errors++;
            $display("FAIL %s idle busy=%b rdata=%h exp busy=0 rdata=%h", tag, busy_o, rsp_rdata_o, last_rdata);
        end
        m_ptr = (w + 1) % N;

        for (int k = 1; k <= r; k++) begin
            tick();
            req_i     = '0;
            hreadyo_i = (k == sa + 1) || (k == sa + sd + 2);
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s busy c%0d got %b exp 1", tag, k, busy_o);
            end
            if (k < r) begin
                checks++;
                if (rsp_valid_o !== '0) begin
                    errors++;
                    $display("FAIL %s early_rsp c%0d got %b exp 0", tag, k, rsp_valid_o);
                end
                if (bad) begin
                    checks++;
                    if (hsel_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s hsel_bad c%0d got %b exp 0", tag, k, hsel_o);
                    end
                end else if (k <= sa + 1) begin
                    checks++;
                    if (hsel_o !== 1'b1 || htrans_o !== 2'b10 || haddr_o !== a_addr[w] || hwrite_o !== a_we[w]) begin
                        errors++;
                        $display("FAIL %s addr_phase c%0d got sel=%b trans=%b addr=%h wr=%b exp 1 10 %h %b",
                                 tag, k, hsel_o, htrans_o, haddr_o, hwrite_o, a_addr[w], a_we[w]);
                    end
                end else begin
                    checks++;
                    if (hsel_o !== 1'b0 || htrans_o !== 2'b00 || hwdata_o !== a_wdata[w]) begin
                        errors++;
                        $display("FAIL %s data_phase c%0d got sel=%b trans=%b wdata=%h exp 0 00 %h",
                                 tag, k, hsel_o, htrans_o, hwdata_o, a_wdata[w]);
                    end
                end
            end else begin
                checks++;
                if (rsp_valid_o !== exp_onehot || rsp_err_o !== exp_err || rsp_rdata_o !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s rsp c%0d got v=%b err=%b rdata=%h exp v=%b err=%b rdata=%h",
                             tag, k, rsp_valid_o, rsp_err_o, rsp_rdata_o, exp_onehot, exp_err, exp_rdata);
                end
                checks++;
                if (hsel_o !== 1'b0 || htrans_o !== 2'b00) begin
                    errors++;
                    $display("FAIL %s rsp_ahb_idle got sel=%b trans=%b exp 0 00", tag, hsel_o, htrans_o);
                end
            end
        end
        hreadyo_i  = 1'b0;
        last_rdata = exp_rdata;
        $display("txn %s req=%b win=%0d addr=%h we=%b rsp_cycle=%0d err=%b rdata=%h",
                 tag, mask, w, a_addr[w], a_we[w], r, exp_err, exp_rdata);
    endtask

    task automatic test_reset;
        rst_i     = 1'b1;
        req_i     = '0;
        hreadyo_i = 1'b0;
        hresp_i   = 2'b00;
        hrdata_i  = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_we[i] = 1'b0;
        end
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (gnt_o !== '0 || rsp_valid_o !== '0 || rsp_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got gnt=%b v=%b err=%b busy=%b exp all 0", gnt_o, rsp_valid_o, rsp_err_o, busy_o);
        end
        checks++;
        if (hsel_o !== 1'b0 || htrans_o !== 2'b00 || hwrite_o !== 1'b0 || haddr_o !== '0 || hwdata_o !== '0) begin
            errors++;
            $display("FAIL reset_ahb got sel=%b trans=%b wr=%b addr=%h wdata=%h exp all 0",
                     hsel_o, htrans_o, hwrite_o, haddr_o, hwdata_o);
        end
        checks++;
        if (rsp_rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0", rsp_rdata_o);
        end
        tick();
        rst_i      = 1'b0;
        m_ptr      = 0;
        last_rdata = '0;
    endtask

    task automatic test_single_read;
        a_addr[0] = 32'h80100004; a_we[0] = 1'b0;
        run_txn("single_read", 2'b01, 0, 0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_round_robin;
        a_addr[0] = 32'h80100010; a_we[0] = 1'b0;
        a_addr[1] = 32'h80100020; a_we[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_txn("round_robin", 2'b11, 0, 0, $urandom, 1'b0);
        end
    endtask

    task automatic test_write_wait;
        a_addr[0] = 32'h80100000; a_wdata[0] = 32'h1; a_we[0] = 1'b1;
        run_txn("write_wait", 2'b01, 0, 3, 32'h12345678, 1'b0);
        run_txn("slave_error", 2'b01, 1, 1, 32'h0, 1'b1);
    endtask

    task automatic test_timeout;
        a_addr[1] = 32'h80100ffc; a_we[1] = 1'b0;
        run_txn("timeout_addr", 2'b10, 40, 0, 32'hCAFEF00D, 1'b0);
        run_txn("timeout_data", 2'b10, 2, 40, 32'hCAFEF00D, 1'b0);
        run_txn("max_wait_ok", 2'b10, 5, 10, 32'h0BADF00D, 1'b0);
    endtask

    task automatic test_bad_addr;
        a_addr[1] = 32'h80101000; a_we[1] = 1'b0;
        run_txn("out_of_window", 2'b10, 0, 0, 32'h11111111, 1'b0);
        a_addr[1] = 32'h80100002;
        run_txn("misaligned", 2'b10, 0, 0, 32'h22222222, 1'b0);
    endtask

    task automatic test_reset_mid;
        a_addr[0] = 32'h80100008; a_we[0] = 1'b0;
        run_txn("pre_reset", 2'b01, 0, 0, 32'h55AA55AA, 1'b0);
        tick();
        req_i     = 2'b01;
        hreadyo_i = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_gnt got %b exp 01", gnt_o);
        end
        tick();
        req_i     = '0;
        hreadyo_i = 1'b1;
        tick();
        hreadyo_i = 1'b0;
        rst_i     = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || hsel_o !== 1'b0 || htrans_o !== 2'b00 || haddr_o !== '0 ||
            hwdata_o !== '0 || rsp_valid_o !== '0 || rsp_rdata_o !== '0 || gnt_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b sel=%b trans=%b addr=%h v=%b rdata=%h exp all 0",
                     busy_o, hsel_o, htrans_o, haddr_o, rsp_valid_o, rsp_rdata_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== '0) begin
                errors++;
                $display("FAIL reset_mid_no_rsp got %b exp 0", rsp_valid_o);
            end
        end
        m_ptr      = 0;
        last_rdata = '0;
        a_addr[1]  = 32'h80100100; a_we[1] = 1'b0;
        run_txn("post_reset", 2'b11, 0, 0, 32'h76543210, 1'b0);
    endtask

    task automatic test_random;
        logic [N-1:0] mask;
        int           sa;
        int           sd;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                a_we[i]    = $urandom_range(0, 1);
                a_wdata[i] = $urandom;
                case ($urandom_range(0, 7))
                    0:       a_addr[i] = 32'h80100000 + 32'h1000 * $urandom_range(1, 4);
                    1:       a_addr[i] = 32'h80100000 | ($urandom & 32'hffc) | $urandom_range(1, 3);
                    default: a_addr[i] = 32'h80100000 | ($urandom & 32'hffc);
                endcase
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            sa   = $urandom_range(0, 3);
            sd   = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) sd = 18;
            run_txn("random", mask, sa, sd, $urandom, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_timeout();
        test_bad_addr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
